// File: rtl/seq_alu_pkg.sv
// Shared alucode constants, FSM state type and op-class helper for seq_alu.
// The M-extension codes are only executed when SEQ_ALU_MULDIV_EN is defined.
package seq_alu_pkg;

   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_SLL    = 5'd2;
   localparam logic [4:0] ALU_SLT    = 5'd3;
   localparam logic [4:0] ALU_SLTU   = 5'd4;
   localparam logic [4:0] ALU_XOR    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_OR     = 5'd8;
   localparam logic [4:0] ALU_AND    = 5'd9;
   localparam logic [4:0] ALU_MUL    = 5'd10;
   localparam logic [4:0] ALU_MULH   = 5'd11;
   localparam logic [4:0] ALU_MULHSU = 5'd12;
   localparam logic [4:0] ALU_MULHU  = 5'd13;
   localparam logic [4:0] ALU_DIV    = 5'd14;
   localparam logic [4:0] ALU_DIVU   = 5'd15;
   localparam logic [4:0] ALU_REM    = 5'd16;
   localparam logic [4:0] ALU_REMU   = 5'd17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic isMulDiv(input logic [4:0] code);
      return (code >= ALU_MUL) && (code <= ALU_REMU);
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per cycle
// on operand magnitudes, with sign correction applied to the final step's output.
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   logic            r_busy, r_isDiv, r_negQ, r_negR, r_divZero;
   logic [4:0]      r_op;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_hi, r_lo, r_b, r_xOrig;

   logic            w_xNeg, w_yNeg, w_isDiv;
   logic [XLEN-1:0] w_xMag, w_yMag, w_hiNext, w_loNext, w_quo, w_rem;
   logic [XLEN:0]   w_sum, w_shift, w_diff;
   logic [2*XLEN-1:0] w_prod, w_prodS;

   assign w_isDiv = (op >= ALU_DIV) && (op <= ALU_REMU);
   assign w_xNeg  = x[XLEN-1] && (op == ALU_MULH || op == ALU_MULHSU || op == ALU_DIV || op == ALU_REM);
   assign w_yNeg  = y[XLEN-1] && (op == ALU_MULH || op == ALU_DIV || op == ALU_REM);
   assign w_xMag  = w_xNeg ? -x : x;
   assign w_yMag  = w_yNeg ? -y : y;

   // r_lo holds the multiplier (mul) or the dividend shifting into the quotient (div)
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_diff  = w_shift - {1'b0, r_b};
      if (r_isDiv) begin
         w_hiNext = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
         w_loNext = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
      end else begin
         w_hiNext = w_sum[XLEN:1];
         w_loNext = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   always_comb begin
      w_prod  = {w_hiNext, w_loNext};
      w_prodS = r_negQ ? -w_prod : w_prod;
      w_quo   = r_negQ ? -w_loNext : w_loNext;
      w_rem   = r_negR ? -w_hiNext : w_hiNext;
      case (r_op)
         ALU_MUL:                         result = w_prodS[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: result = w_prodS[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:               result = r_divZero ? '1 : w_quo;
         ALU_REM, ALU_REMU:               result = r_divZero ? r_xOrig : w_rem;
         default:                         result = '1;
      endcase
   end

   assign done = r_busy && (r_count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy    <= 1'b0;
         r_isDiv   <= 1'b0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
         r_divZero <= 1'b0;
         r_op      <= '0;
         r_count   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_xOrig   <= '0;
      end else if (start) begin
         r_busy    <= 1'b1;
         r_isDiv   <= w_isDiv;
         r_negQ    <= w_xNeg ^ w_yNeg;
         r_negR    <= w_xNeg;
         r_divZero <= (y == '0);
         r_op      <= op;
         r_count   <= '0;
         r_hi      <= '0;
         r_lo      <= w_xMag;
         r_b       <= w_yMag;
         r_xOrig   <= x;
      end else if (r_busy) begin
         r_hi    <= w_hiNext;
         r_lo    <= w_loNext;
         r_count <= r_count + 1'b1;
         if (r_count == LAST) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; base ops answer in one cycle.
// Define SEQ_ALU_MULDIV_EN to add the iterative multiply/divide engine.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] r1,
   input  logic [XLEN-1:0] r2,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [4:0]      alucode,
   input  logic            using_r2,
   input  logic            using_pc,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result
);

   state_t          r_state;
   logic [XLEN-1:0] w_x, w_y, w_aluOut;
   logic [SHW-1:0]  w_shamt;
   logic            w_accept;

   assign w_x      = using_pc ? pc : r1;
   assign w_y      = using_r2 ? r2 : imm;
   assign w_shamt  = w_y[SHW-1:0];
   assign in_ready = (r_state == IDLE);
   assign w_accept = in_valid && in_ready;

   always_comb begin
      case (alucode)
         ALU_ADD:  w_aluOut = w_x + w_y;
         ALU_SUB:  w_aluOut = w_x - w_y;
         ALU_AND:  w_aluOut = w_x & w_y;
         ALU_OR:   w_aluOut = w_x | w_y;
         ALU_XOR:  w_aluOut = w_x ^ w_y;
         ALU_SLT:  w_aluOut = {{(XLEN-1){1'b0}}, $signed(w_x) < $signed(w_y)};
         ALU_SLTU: w_aluOut = {{(XLEN-1){1'b0}}, w_x < w_y};
         ALU_SLL:  w_aluOut = w_x << w_shamt;
         ALU_SRL:  w_aluOut = w_x >> w_shamt;
         ALU_SRA:  w_aluOut = $signed(w_x) >>> w_shamt;
         default:  w_aluOut = '1;
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN
   logic            w_mdStart, w_mdDone;
   logic [XLEN-1:0] w_mdResult;

   assign w_mdStart = w_accept && isMulDiv(alucode);

   seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (w_mdStart),
      .op     (alucode),
      .x      (w_x),
      .y      (w_y),
      .done   (w_mdDone),
      .result (w_mdResult)
   );
`endif

   // The result register is written once per operation and held through DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         out_valid  <= 1'b0;
         alu_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
`ifdef SEQ_ALU_MULDIV_EN
                  if (isMulDiv(alucode)) begin
                     r_state <= BUSY;
                  end else begin
                     alu_result <= w_aluOut;
                     out_valid  <= 1'b1;
                     r_state    <= DONE;
                  end
`else
                  alu_result <= w_aluOut;
                  out_valid  <= 1'b1;
                  r_state    <= DONE;
`endif
               end
            end
            BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
               if (w_mdDone) begin
                  alu_result <= w_mdResult;
                  out_valid  <= 1'b1;
                  r_state    <= DONE;
               end
`else
               r_state <= IDLE;
`endif
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
